// File: rtl/hamming_serial_decoder_pkg.sv
// Shared Hamming code definitions: code geometry, position helpers and the
// decode classification. Intended for reuse by the matching encoder.
package hamming_serial_decoder_pkg;

  // Outcome of decoding one codeword.
  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'd0,  // no error seen
    CLS_SINGLE = 2'd1,  // single error at position = syndrome, flipped back
    CLS_PARITY = 2'd2,  // only the overall-parity bit (pos 0) was wrong
    CLS_DOUBLE = 2'd3   // two errors: detected, not correctable
  } cls_e;

  // Hamming bits per codeword for R parity bits.
  function automatic int hm_n(input int r);
    return (1 << r) - 1;
  endfunction

  // Data bits per codeword for R parity bits.
  function automatic int hm_k(input int r);
    return hm_n(r) - r;
  endfunction

  // Parity bits live at power-of-2 positions; everything else carries data.
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit idx (data[0] sits at position 3).
  function automatic int data_pos(input int r, input int idx);
    int res  = 0;
    int seen = 0;
    for (int p = 1; p <= hm_n(r); p++) begin
      if (!is_pow2(p)) begin
        if (seen == idx) res = p;
        seen++;
      end
    end
    return res;
  endfunction

  // Bit counter width: must hold frame length N+SECDED.
  function automatic int cnt_w(input int r, input int secded);
    return $clog2(hm_n(r) + secded + 1);
  endfunction

endpackage

// File: rtl/hamming_serial_decoder_acc.sv
// Per-bit position counter plus running syndrome / overall-parity
// accumulators. A start-of-frame bit restarts the frame; the last bit of a
// frame wraps everything back to zero so frames can run back-to-back.
module hamming_syndrome_acc
  import hamming_serial_decoder_pkg::*;
#(
  parameter int R      = 3,
  parameter bit SECDED = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_sof,
  output logic [R-1:0] acc_pos,    // codeword position of the current bit
  output logic         acc_last,   // current bit completes the frame
  output logic [R-1:0] syn_final,  // syndrome including the current bit
  output logic         par_final   // overall parity including the current bit
);

  localparam int N  = hm_n(R);
  localparam int L  = N + int'(SECDED);
  localparam int CW = cnt_w(R, int'(SECDED));
  // Without the overall-parity bit the first received bit is position 1.
  localparam logic [CW-1:0] POS_OFF = CW'(SECDED ? 0 : 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic [R-1:0]  syn_q, syn_d, syn_base;
  logic          par_q, par_d, par_base;
  logic          restart;

  // Next position/accumulator values, honouring sof restart and frame wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    restart   = in_valid && in_sof;
    cnt_eff   = restart ? '0 : cnt_q;
    syn_base  = restart ? '0 : syn_q;
    par_base  = restart ? 1'b0 : par_q;
    acc_pos   = R'(cnt_eff + POS_OFF);
    acc_last  = (cnt_eff == CW'(L - 1));
    syn_final = syn_base ^ (in_bit ? acc_pos : '0);
    par_final = par_base ^ in_bit;
    cnt_d     = cnt_q;
    syn_d     = syn_q;
    par_d     = par_q;
    if (in_valid) begin
      if (acc_last) begin
        cnt_d = '0;
        syn_d = '0;
        par_d = 1'b0;
      end else begin
        cnt_d = cnt_eff + CW'(1);
        syn_d = syn_final;
        par_d = par_final;
      end
    end
  end

  // Counter and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      cnt_q <= cnt_d;
      syn_q <= syn_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial Hamming (optionally SECDED) decoder: collects one codeword bit per
// accepted in_valid, corrects/classifies on the last bit and presents the
// data word through a one-deep registered valid/ready output stage.
module hamming_serial_decoder
  import hamming_serial_decoder_pkg::*;
#(
  parameter  int R      = 3,
  parameter  bit SECDED = 1'b0,
  localparam int N      = hm_n(R),
  localparam int K      = hm_k(R)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_sof,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic [R-1:0] out_syndrome,
  output logic         out_corrected,
  output logic         out_uncorrectable,
  output logic         overrun
);

  logic [R-1:0] acc_pos, syn_final;
  logic         acc_last, par_final;

  hamming_syndrome_acc #(.R(R), .SECDED(SECDED)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_sof   (in_sof),
    .acc_pos  (acc_pos),
    .acc_last (acc_last),
    .syn_final(syn_final),
    .par_final(par_final)
  );

  // Position 0 is never stored: it only feeds the parity accumulator.
  logic [N:1]   cw_q, cw_d, cw_full, fix;
  logic [K-1:0] data_ext;
  cls_e         cls;

  logic [K-1:0] data_q, data_d;
  logic [R-1:0] syn_q, syn_d;
  logic         corr_q, corr_d, unc_q, unc_d, valid_q, valid_d, ovr_q, ovr_d;
  logic         complete, load;

  // Codeword store with the current bit already merged in.
  always_comb begin
    cw_full = cw_q;
    for (int p = 1; p <= N; p++) begin
      if (acc_pos == R'(p)) cw_full[p] = in_bit;
    end
    cw_d = in_valid ? cw_full : cw_q;
  end

  // Classify the completed word and undo a single-bit error.
  always_comb begin
    cls = CLS_CLEAN;
    if (SECDED) begin
      if (syn_final != '0 && par_final)       cls = CLS_SINGLE;
      else if (syn_final == '0 && par_final)  cls = CLS_PARITY;
      else if (syn_final != '0)               cls = CLS_DOUBLE;
    end else if (syn_final != '0) begin
      cls = CLS_SINGLE;
    end
    fix = cw_full;
    if (cls == CLS_SINGLE) begin
      for (int p = 1; p <= N; p++) begin
        if (syn_final == R'(p)) fix[p] = ~fix[p];
      end
    end
  end

  // Data bits are the non-power-of-2 positions, lowest position first.
  for (genvar i = 0; i < K; i++) begin : g_extract
    localparam int P = data_pos(R, i);
    assign data_ext[i] = fix[P];
  end

  // One-deep output register: load on completion if empty or draining,
  // otherwise drop the new word and flag overrun.
  always_comb begin
    complete = in_valid && acc_last;
    load     = complete && (!valid_q || out_ready);
    valid_d  = valid_q;
    data_d   = data_q;
    syn_d    = syn_q;
    corr_d   = corr_q;
    unc_d    = unc_q;
    ovr_d    = ovr_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_ext;
      syn_d   = syn_final;
      corr_d  = (cls == CLS_SINGLE) || (cls == CLS_PARITY);
      unc_d   = (cls == CLS_DOUBLE);
    end
    if (complete && valid_q && !out_ready) ovr_d = 1'b1;
  end

  // Codeword store and output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the codeword store is tiny, so it is reset like any other flop rather than left as uninitialised memory.
      cw_q    <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cw_q    <= cw_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_data          = data_q;
  assign out_syndrome      = syn_q;
  assign out_corrected     = corr_q;
  assign out_uncorrectable = unc_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Bench for hamming_serial_decoder: instance 0 is R=3 plain Hamming,
// instance 1 is R=3 SECDED. A frame-level model decodes each completed
// frame from first principles and a compare process checks every cycle.
module tb_hamming_serial_decoder;

  localparam int R = 3;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid [2];
  logic in_bit   [2];
  logic in_sof   [2];
  logic out_ready[2];
  logic [K-1:0] out_data[2];
  logic [R-1:0] out_syndrome[2];
  logic out_valid[2], out_corrected[2], out_uncorrectable[2], overrun[2];

  always #5 clk = ~clk;

  hamming_serial_decoder #(.R(R), .SECDED(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_bit(in_bit[0]), .in_sof(in_sof[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_syndrome(out_syndrome[0]), .out_corrected(out_corrected[0]),
    .out_uncorrectable(out_uncorrectable[0]), .overrun(overrun[0])
  );

  hamming_serial_decoder #(.R(R), .SECDED(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_bit(in_bit[1]), .in_sof(in_sof[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_syndrome(out_syndrome[1]), .out_corrected(out_corrected[1]),
    .out_uncorrectable(out_uncorrectable[1]), .overrun(overrun[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
    logic       unc;
  } word_t;

  function automatic int frame_len(input int i);
    return (i == 1) ? 8 : 7;
  endfunction

  // Decode a received frame (bit j = j-th bit on the wire) from the code rules.
  function automatic word_t decode(input logic [7:0] fr, input bit secded);
    word_t      w;
    logic [7:0] cw = '0;   // indexed by codeword position 0..7
    logic [2:0] syn = '0;
    logic       par = 1'b0;
    bit         flip = 1'b0;
    int         idx = 0;
    for (int j = 0; j < (secded ? 8 : 7); j++) begin
      int pos = secded ? j : j + 1;
      cw[pos[2:0]] = fr[j[2:0]];
    end
    for (int p = 0; p < 8; p++) begin
      par = par ^ cw[p[2:0]];
      if (p > 0 && cw[p[2:0]]) syn = syn ^ p[2:0];
    end
    w.corr = 1'b0;
    w.unc  = 1'b0;
    if (!secded) begin
      flip   = (syn != 0);
      w.corr = flip;
    end else if (syn != 0 && par) begin
      flip   = 1'b1;
      w.corr = 1'b1;
    end else if (syn == 0 && par) begin
      w.corr = 1'b1;
    end else if (syn != 0) begin
      w.unc = 1'b1;
    end
    if (flip) cw[syn] = ~cw[syn];
    w.data = '0;
    for (int p = 1; p < 8; p++) begin
      if ((p & (p - 1)) != 0) begin
        w.data[idx[1:0]] = cw[p[2:0]];
        idx++;
      end
    end
    w.syn = syn;
    return w;
  endfunction

  // Behavioural model state.
  logic [7:0] fr[2];
  int         nbits[2];
  bit         exp_v[2];
  bit         exp_o[2];
  word_t      exp_w[2];

  // Frame-level reference: collect bits, decode on completion, model the
  // one-deep output with drop-and-flag on overflow.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fr[i]    = '0;
        nbits[i] = 0;
        exp_v[i] = 1'b0;
        exp_o[i] = 1'b0;
        exp_w[i] = '{data: '0, syn: '0, corr: 1'b0, unc: 1'b0};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit was_v;
        was_v = exp_v[i];
        if (was_v && out_ready[i]) exp_v[i] = 1'b0;
        if (in_valid[i]) begin
          if (in_sof[i]) nbits[i] = 0;
          fr[i][nbits[i][2:0]] = in_bit[i];
          nbits[i]++;
          if (nbits[i] == frame_len(i)) begin
            nbits[i] = 0;
            if (!was_v || out_ready[i]) begin
              exp_v[i] = 1'b1;
              exp_w[i] = decode(fr[i], i == 1);
            end else begin
              exp_o[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("d%0d out_valid", i), 32'(out_valid[i]), 32'(exp_v[i]));
        check($sformatf("d%0d overrun", i), 32'(overrun[i]), 32'(exp_o[i]));
        if (exp_v[i]) begin
          check($sformatf("d%0d out_data", i), 32'(out_data[i]), 32'(exp_w[i].data));
          check($sformatf("d%0d out_syndrome", i), 32'(out_syndrome[i]), 32'(exp_w[i].syn));
          check($sformatf("d%0d out_corrected", i), 32'(out_corrected[i]), 32'(exp_w[i].corr));
          check($sformatf("d%0d out_uncorrectable", i), 32'(out_uncorrectable[i]),
                32'(exp_w[i].unc));
        end
      end
    end
  end

  task automatic send_bit(input int i, input logic b, input logic sof);
    in_valid[i] = 1'b1;
    in_bit[i]   = b;
    in_sof[i]   = sof;
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_sof[i]   = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] bits, input logic sof);
    for (int j = 0; j < frame_len(i); j++) send_bit(i, bits[j], sof && (j == 0));
  endtask

  task automatic check_word(input string tag, input int i, input logic [3:0] data,
                            input logic [2:0] syn, input logic corr, input logic unc);
    check({tag, " valid"}, 32'(out_valid[i]), 32'd1);
    check({tag, " data"}, 32'(out_data[i]), 32'(data));
    check({tag, " syndrome"}, 32'(out_syndrome[i]), 32'(syn));
    check({tag, " corrected"}, 32'(out_corrected[i]), 32'(corr));
    check({tag, " uncorrectable"}, 32'(out_uncorrectable[i]), 32'(unc));
  endtask

  task automatic check_zero(input string tag, input int i);
    check({tag, " valid"}, 32'(out_valid[i]), 32'd0);
    check({tag, " data"}, 32'(out_data[i]), 32'd0);
    check({tag, " syndrome"}, 32'(out_syndrome[i]), 32'd0);
    check({tag, " corrected"}, 32'(out_corrected[i]), 32'd0);
    check({tag, " uncorrectable"}, 32'(out_uncorrectable[i]), 32'd0);
    check({tag, " overrun"}, 32'(overrun[i]), 32'd0);
  endtask

  task automatic rand_drive(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      in_valid[i]  = ($urandom_range(0, 3) != 0);
      in_bit[i]    = 1'($urandom_range(0, 1));
      in_sof[i]    = ($urandom_range(0, 29) == 0);
      out_ready[i] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid[i]  = 1'b0;
    in_sof[i]    = 1'b0;
    out_ready[i] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_bit[i]    = 1'b0;
      in_sof[i]    = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    check_zero("reset d0", 0);
    check_zero("reset d1", 1);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: clean word, output one cycle after the last bit, then drained.
    for (int j = 0; j < 6; j++) send_bit(0, 1'(8'h55 >> j), 1'b0);
    check("t1 valid before last bit", 32'(out_valid[0]), 32'd0);
    send_bit(0, 1'b1, 1'b0);
    check_word("t1 clean", 0, 4'b1011, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1 valid after handshake", 32'(out_valid[0]), 32'd0);

    // 2: single error at position 5.
    send_frame(0, 8'h45, 1'b0);
    check_word("t2 single", 0, 4'b1011, 3'd5, 1'b1, 1'b0);

    // 3: SECDED double error (positions 2 and 6).
    send_frame(1, 8'hEE, 1'b0);
    check_word("t3 double", 1, 4'b1111, 3'd4, 1'b0, 1'b1);

    // 4: SECDED error in the overall-parity bit only; plus a clean SECDED word.
    send_frame(1, 8'hAB, 1'b0);
    check_word("t4 parity bit", 1, 4'b1011, 3'd0, 1'b1, 1'b0);
    send_frame(1, 8'hAA, 1'b0);
    check_word("t4 clean secded", 1, 4'b1011, 3'd0, 1'b0, 1'b0);

    // 5: consumer stalled over two back-to-back frames.
    out_ready[0] = 1'b0;
    send_frame(0, 8'h55, 1'b0);
    check_word("t5 first held", 0, 4'b1011, 3'd0, 1'b0, 1'b0);
    check("t5 overrun before drop", 32'(overrun[0]), 32'd0);
    send_frame(0, 8'h45, 1'b0);
    check_word("t5 still first", 0, 4'b1011, 3'd0, 1'b0, 1'b0);
    check("t5 overrun set", 32'(overrun[0]), 32'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("t5 valid drained", 32'(out_valid[0]), 32'd0);
    check("t5 overrun sticky", 32'(overrun[0]), 32'd1);

    // 6: sof resync after a partial frame.
    for (int j = 0; j < 4; j++) send_bit(0, 1'b1, j == 0);
    check("t6 no output from partial", 32'(out_valid[0]), 32'd0);
    send_frame(0, 8'h45, 1'b1);
    check_word("t6 resync", 0, 4'b1011, 3'd5, 1'b1, 1'b0);

    // 6b: reset mid-frame discards the partial frame and clears everything.
    @(negedge clk);
    for (int j = 0; j < 3; j++) send_bit(0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_zero("t6 reset d0", 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 8'h55, 1'b0);
    check_word("t6 after reset", 0, 4'b1011, 3'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Randomized traffic on both instances, checked by the model every cycle.
    fork
      rand_drive(0, 3000);
      rand_drive(1, 3000);
    join
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
